// File: rtl/mcac_sched_pkg.sv
// Shared constants, state encoding and write latency for the coefficient-update scheduler.
// Optional build macro: BCOEF_SCHED_PIPE_EN (adds one datapath register stage, WL=2).
package mcac_sched_pkg;

  localparam int NTAP  = 6;
  localparam int TAP_W = 3;

`ifdef BCOEF_SCHED_PIPE_EN
  localparam int WL = 2;
`else
  localparam int WL = 1;
`endif

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/bsched_wr_pipe.sv
// WL-deep register chain delaying the read strobe {en, ch, tap} into the write strobe.
// Depth follows mcac_sched_pkg::WL, which depends on BCOEF_SCHED_PIPE_EN.
module bsched_wr_pipe
  import mcac_sched_pkg::*;
#(
  parameter int CHW   = 5,
  parameter int DEPTH = WL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_en,
  input  logic [CHW-1:0]   rd_ch,
  input  logic [TAP_W-1:0] rd_tap,
  output logic             wr_en,
  output logic [CHW-1:0]   wr_ch,
  output logic [TAP_W-1:0] wr_tap
);

  localparam int W = 1 + CHW + TAP_W;

  logic [W-1:0] stg [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
    end else begin
      stg[0] <= {rd_en, rd_ch, rd_tap};
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign {wr_en, wr_ch, wr_tap} = stg[DEPTH-1];

endmodule

// File: rtl/bcoef_update_sched.sv
// Sequences six tap reads, delayed write-backs and one DQ shift per channel update.
// BCOEF_SCHED_PIPE_EN selects WL=2 (two DRAIN cycles) instead of WL=1.
module bcoef_update_sched
  import mcac_sched_pkg::*;
#(
  parameter int NCH = 32,
  parameter int CHW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CHW-1:0]   ch_in,
  input  logic             tr_in,
  input  logic [1:0]       rate_in,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [CHW-1:0]   rd_ch,
  output logic [TAP_W-1:0] rd_tap,
  output logic             wr_en,
  output logic [CHW-1:0]   wr_ch,
  output logic [TAP_W-1:0] wr_tap,
  output logic [1:0]       dp_rate,
  output logic             dp_tr,
  output logic             dqn_shift,
  output logic             err_overrun,
  output state_t           fsm_state
);

  localparam logic [1:0] DRAIN_LAST = 2'(WL - 1);

  // Handshake: start is a one-cycle request with no ready; it is accepted only
  // in IDLE with an in-range channel, otherwise it is dropped and flagged.

  state_t           state, state_nxt;
  logic [CHW-1:0]   ch_q;
  logic             tr_q;
  logic [1:0]       rate_q;
  logic [TAP_W-1:0] tap_cnt;
  logic [1:0]       drain_cnt;
  logic             err_q;
  logic             in_range;
  logic             accept;
  logic             reject;

  // Widened compare keeps power-of-two NCH (where NCH does not fit in CHW) correct.
  assign in_range = ({1'b0, ch_in} < (CHW+1)'(NCH));
  assign accept   = start && (state == IDLE) && in_range;
  assign reject   = start && !accept;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_tap    = '0;
    done      = 1'b0;
    dqn_shift = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: begin
        rd_en  = 1'b1;
        rd_tap = tap_cnt;
        if (tap_cnt == LAST_TAP) state_nxt = DRAIN;
      end
      DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = FIN;
      FIN: begin
        done      = 1'b1;
        dqn_shift = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q      <= '0;
      tr_q      <= 1'b0;
      rate_q    <= '0;
      tap_cnt   <= '0;
      drain_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        ch_q    <= ch_in;
        tr_q    <= tr_in;
        rate_q  <= rate_in;
        tap_cnt <= '0;
      end else if (state == ISSUE) begin
        tap_cnt <= (tap_cnt == LAST_TAP) ? '0 : tap_cnt + 1'b1;
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      if (reject) err_q <= 1'b1;
    end
  end

  assign busy        = (state != IDLE);
  assign rd_ch       = ch_q;
  assign dp_rate     = rate_q;
  assign dp_tr       = tr_q;
  assign err_overrun = err_q;
  assign fsm_state   = state;

  bsched_wr_pipe #(.CHW(CHW), .DEPTH(WL)) u_wr_pipe (
    .clk    (clk),
    .reset  (reset),
    .rd_en  (rd_en),
    .rd_ch  (rd_ch),
    .rd_tap (rd_tap),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_tap (wr_tap)
  );

endmodule

// File: tb/tb_bcoef_update_sched.sv
// Directed bench for bcoef_update_sched (NCH=24); honours BCOEF_SCHED_PIPE_EN for write latency.
module tb_bcoef_update_sched;
  import mcac_sched_pkg::*;

  localparam int NCH = 24;
  localparam int CHW = $clog2(NCH);
`ifdef BCOEF_SCHED_PIPE_EN
  localparam int TB_WL = 2;
`else
  localparam int TB_WL = 1;
`endif
  localparam int FIN_C = 7 + TB_WL;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [CHW-1:0] ch_in;
  logic           tr_in;
  logic [1:0]     rate_in;
  logic           busy, done, rd_en, wr_en, dp_tr, dqn_shift, err_overrun;
  logic [CHW-1:0] rd_ch, wr_ch;
  logic [2:0]     rd_tap, wr_tap;
  logic [1:0]     dp_rate;
  state_t         fsm_state;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  bcoef_update_sched #(.NCH(NCH)) dut (
    .clk(clk), .reset(reset), .start(start), .ch_in(ch_in), .tr_in(tr_in),
    .rate_in(rate_in), .busy(busy), .done(done), .rd_en(rd_en), .rd_ch(rd_ch),
    .rd_tap(rd_tap), .wr_en(wr_en), .wr_ch(wr_ch), .wr_tap(wr_tap),
    .dp_rate(dp_rate), .dp_tr(dp_tr), .dqn_shift(dqn_shift),
    .err_overrun(err_overrun), .fsm_state(fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_ch"}, rd_ch, 0);
    check({tag, "_rd_tap"}, rd_tap, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_ch"}, wr_ch, 0);
    check({tag, "_wr_tap"}, wr_tap, 0);
    check({tag, "_dp_rate"}, dp_rate, 0);
    check({tag, "_dp_tr"}, dp_tr, 0);
    check({tag, "_dqn"}, dqn_shift, 0);
    check({tag, "_err"}, err_overrun, 0);
  endtask

  // Starts an update in the current cycle and checks cycles 1..FIN+1.
  // ovr_cyc > 0 injects a second start (ch 7) in that cycle.
  task automatic run_op(input int ch, input bit tr, input bit [1:0] rate,
                        input int ovr_cyc, input bit err_before);
    logic [7:0] e;
    int nwr;
    int nshift;
    nwr = 0;
    nshift = 0;
    for (int t = 0; t < 6; t++) exp_q.push_back(8'((ch << 3) | t));
    start = 1'b1; ch_in = CHW'(ch); tr_in = tr; rate_in = rate;
    step();
    start = 1'b0;
    for (int k = 1; k <= FIN_C; k++) begin
      check("busy", busy, 1);
      check("rd_en", rd_en, (k <= 6) ? 1 : 0);
      if (k <= 6) begin
        check("rd_tap", rd_tap, k - 1);
        check("rd_ch", rd_ch, ch);
      end
      check("wr_en", wr_en, (k >= 1 + TB_WL && k <= 6 + TB_WL) ? 1 : 0);
      if (wr_en) begin
        nwr++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_ch_tap", {wr_ch, wr_tap}, e);
        end else begin
          check("wr_extra", 1, 0);
        end
      end
      if (dqn_shift) nshift++;
      check("done", done, (k == FIN_C) ? 1 : 0);
      check("dqn_shift", dqn_shift, (k == FIN_C) ? 1 : 0);
      check("dp_rate", dp_rate, rate);
      check("dp_tr", dp_tr, tr);
      if (ovr_cyc > 0 && k > ovr_cyc) check("err_overrun", err_overrun, 1);
      else                            check("err_overrun", err_overrun, err_before);
      if (k == ovr_cyc) begin
        start = 1'b1; ch_in = CHW'(7); tr_in = ~tr; rate_in = ~rate;
      end
      step();
      start = 1'b0;
    end
    check("busy_after", busy, 0);
    check("done_after", done, 0);
    check("wr_count", nwr, 6);
    check("shift_count", nshift, 1);
    check("exp_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ch_in = '0; tr_in = 1'b0; rate_in = '0;
    step();
    step();
    reset = 1'b0;
    check_all_zero("reset");

    // Basic update
    run_op(5, 1'b0, 2'b11, 0, 1'b0);
    // Trigger
    run_op(0, 1'b1, 2'b01, 0, 1'b0);
    // Back-to-back: second start lands in the single idle cycle
    run_op(1, 1'b0, 2'b10, 0, 1'b0);
    run_op(2, 1'b1, 2'b00, 0, 1'b0);
    check("b2b_err", err_overrun, 0);
    // Overrun at cycle 3
    run_op(4, 1'b0, 2'b10, 3, 1'b0);
    step();
    check("ovr_sticky", err_overrun, 1);

    // Reset mid-operation at cycle 4
    start = 1'b1; ch_in = CHW'(3); tr_in = 1'b1; rate_in = 2'b10;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check("mid_rd_en", rd_en, 1);
      if (k == 4) reset = 1'b1;
      step();
    end
    reset = 1'b0;
    check_all_zero("mid_reset");
    exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      check("post_rst_rd", rd_en, 0);
      check("post_rst_wr", wr_en, 0);
      check("post_rst_dqn", dqn_shift, 0);
      check("post_rst_busy", busy, 0);
      step();
    end
    run_op(5, 1'b0, 2'b11, 0, 1'b0);

    // Out-of-range channel (NCH=24)
    start = 1'b1; ch_in = CHW'(30); tr_in = 1'b0; rate_in = 2'b01;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("oor_busy", busy, 0);
      check("oor_rd_en", rd_en, 0);
      check("oor_err", err_overrun, 1);
      step();
    end
    // Highest legal channel still accepted
    run_op(23, 1'b0, 2'b01, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
